// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the victim-cache write-back path.
package lc3b_types;

   typedef logic [127:0] lc3b_line;
   typedef logic [11:0]  lc3b_line_addr;

   typedef enum logic [0:0] {
      VCWB_IDLE,
      VCWB_WRITE
   } vc_wb_state_t;

endpackage

// File: rtl/vc_wb_queue.sv
// Circular store of pending dirty lines with head/tail pointers, occupancy count
// and a youngest-match combinational lookup.
module vc_wb_queue
   import lc3b_types::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 128
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [ADDR_W-1:0]          head_addr,
   output logic [DATA_W-1:0]          head_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic [ADDR_W-1:0]          lookup_address,
   output logic                       lookup_hit,
   output logic [DATA_W-1:0]          lookup_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_en, pop_en;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];

   // Payload storage carries no reset; only the valid bits gate its use.
   always_ff @(posedge clk) begin
      if (push_en) begin
         addr_q[tail_q] <= push_addr;
         data_q[tail_q] <= push_data;
      end
   end

   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop_en) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      if (push_en) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Walk from oldest to youngest so the last match, the youngest, wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx         = '0;
      lookup_hit  = 1'b0;
      lookup_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (valid_q[idx] && (addr_q[idx] == lookup_address)) begin
            lookup_hit  = 1'b1;
            lookup_data = data_q[idx];
         end
      end
   end

endmodule

// File: rtl/vc_wb_drain.sv
// Write-back drain buffer: queues dirty victim lines and retires them to pmem
// one at a time, with a lookup port for pending lines.
module vc_wb_drain
   import lc3b_types::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wb_valid,
   input  logic [ADDR_W-1:0]      wb_address,
   input  logic [DATA_W-1:0]      wb_data,
   output logic                   wb_ready,
   input  logic [ADDR_W-1:0]      lookup_address,
   output logic                   lookup_hit,
   output logic [DATA_W-1:0]      lookup_data,
   output logic [15:0]            pmem_address,
   output logic [DATA_W-1:0]      pmem_wdata,
   output logic                   pmem_write,
   input  logic                   pmem_resp,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   vc_wb_state_t      state_q, state_d;
   logic              full;
   logic              pop;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign wb_ready = !full;

   vc_wb_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_queue (
      .clk            (clk),
      .reset          (reset),
      .push           (wb_valid),
      .push_addr      (wb_address),
      .push_data      (wb_data),
      .pop            (pop),
      .head_addr      (head_addr),
      .head_data      (head_data),
      .full           (full),
      .empty          (empty),
      .count          (count),
      .lookup_address (lookup_address),
      .lookup_hit     (lookup_hit),
      .lookup_data    (lookup_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= VCWB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Returning to IDLE after every response forces a low pmem_write cycle
   // between back-to-back writes.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         VCWB_IDLE: begin
            if (!empty) state_d = VCWB_WRITE;
         end
         VCWB_WRITE: begin
            if (pmem_resp) begin
               pop     = 1'b1;
               state_d = VCWB_IDLE;
            end
         end
         default: state_d = VCWB_IDLE;
      endcase
   end

   assign pmem_write   = (state_q == VCWB_WRITE);
   assign pmem_address = 16'({head_addr, 4'b0000});
   assign pmem_wdata   = head_data;

endmodule

// File: tb/tb_vc_wb_drain.sv
// Directed self-checking bench for vc_wb_drain.
module tb_vc_wb_drain;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 128;

   localparam logic [127:0] DATA_D = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
   localparam logic [127:0] DATA_A = 128'hAAAA0000_AAAA1111_AAAA2222_AAAA3333;
   localparam logic [127:0] DATA_B = 128'hBBBB0000_BBBB1111_BBBB2222_BBBB3333;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wb_valid = 1'b0;
   logic [ADDR_W-1:0] wb_address = '0;
   logic [DATA_W-1:0] wb_data = '0;
   logic              wb_ready;
   logic [ADDR_W-1:0] lookup_address = '0;
   logic              lookup_hit;
   logic [DATA_W-1:0] lookup_data;
   logic [15:0]       pmem_address;
   logic [DATA_W-1:0] pmem_wdata;
   logic              pmem_write;
   logic              pmem_resp = 1'b0;
   logic              empty;
   logic [2:0]        count;

   int n_checks = 0;
   int n_fail   = 0;

   vc_wb_drain #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .wb_valid       (wb_valid),
      .wb_address     (wb_address),
      .wb_data        (wb_data),
      .wb_ready       (wb_ready),
      .lookup_address (lookup_address),
      .lookup_hit     (lookup_hit),
      .lookup_data    (lookup_data),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_write     (pmem_write),
      .pmem_resp      (pmem_resp),
      .empty          (empty),
      .count          (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_line(input logic [11:0] a, input logic [127:0] d);
      wb_valid   = 1'b1;
      wb_address = a;
      wb_data    = d;
      tick();
      wb_valid   = 1'b0;
   endtask

   task automatic wait_write();
      for (int w = 0; w < 20 && pmem_write !== 1'b1; w++) tick();
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %b want 1", wb_ready); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
      n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL reset_lookup_hit: got %b want 0", lookup_hit); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      push_line(12'h0A3, DATA_D);
      lookup_address = 12'h0A3;
      #1;
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
      n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL single_write_early: got %b want 0", pmem_write); end
      n_checks++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL single_lookup_visible: got %b want 1", lookup_hit); end
      tick();
      n_checks++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL single_write_rise: got %b want 1", pmem_write); end
      n_checks++; if (pmem_address !== 16'h0A30) begin n_fail++; $display("FAIL single_address: got %h want 0a30", pmem_address); end
      n_checks++; if (pmem_wdata !== DATA_D) begin n_fail++; $display("FAIL single_wdata: got %h want %h", pmem_wdata, DATA_D); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (pmem_write !== 1'b1 || pmem_address !== 16'h0A30) begin
            n_fail++; $display("FAIL single_hold: write %b addr %h want 1 0a30", pmem_write, pmem_address);
         end
      end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL single_write_drop: got %b want 0", pmem_write); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", empty); end
      tick();
      n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL single_idle_stays: got %b want 0", pmem_write); end
   endtask

   task automatic test_fill();
      logic [15:0] exp_addr;
      for (int k = 1; k <= 4; k++) push_line(12'(k), {96'h0, 32'(k)});
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
      n_checks++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL fill_wb_ready: got %b want 0", wb_ready); end
      push_line(12'h005, 128'h5);
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_reject_5th: got %0d want 4", count); end
      for (int k = 1; k <= 4; k++) begin
         wait_write();
         exp_addr = 16'(k) << 4;
         n_checks++; if (pmem_write !== 1'b1 || pmem_address !== exp_addr) begin
            n_fail++; $display("FAIL fill_drain_order: write %b addr %h want 1 %h", pmem_write, pmem_address, exp_addr);
         end
         pmem_resp = 1'b1;
         tick();
         pmem_resp = 1'b0;
         n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL fill_gap: got %b want 0", pmem_write); end
      end
      lookup_address = 12'h005;
      #1;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b want 1", empty); end
      n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL fill_5th_absent: got %b want 0", lookup_hit); end
   endtask

   task automatic test_back_to_back();
      push_line(12'h011, DATA_A);
      push_line(12'h012, DATA_B);
      n_checks++; if (count !== 3'd2 || pmem_address !== 16'h0110) begin
         n_fail++; $display("FAIL b2b_setup: count %0d addr %h want 2 0110", count, pmem_address);
      end
      wb_valid   = 1'b1;
      wb_address = 12'h013;
      wb_data    = DATA_D;
      pmem_resp  = 1'b1;
      tick();
      wb_valid  = 1'b0;
      pmem_resp = 1'b0;
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", count); end
      tick();
      n_checks++; if (pmem_write !== 1'b1 || pmem_address !== 16'h0120) begin
         n_fail++; $display("FAIL b2b_next_head: write %b addr %h want 1 0120", pmem_write, pmem_address);
      end
      lookup_address = 12'h013;
      #1;
      n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== DATA_D) begin
         n_fail++; $display("FAIL b2b_new_tail: hit %b data %h want 1 %h", lookup_hit, lookup_data, DATA_D);
      end
      lookup_address = 12'h011;
      #1;
      n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL b2b_popped_gone: got %b want 0", lookup_hit); end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      wait_write();
      n_checks++; if (pmem_address !== 16'h0130 || pmem_wdata !== DATA_D) begin
         n_fail++; $display("FAIL b2b_third: addr %h data %h want 0130 %h", pmem_address, pmem_wdata, DATA_D);
      end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", empty); end
   endtask

   task automatic test_lookup_priority();
      push_line(12'h055, DATA_A);
      push_line(12'h055, DATA_B);
      lookup_address = 12'h055;
      #1;
      n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== DATA_B) begin
         n_fail++; $display("FAIL prio_youngest: hit %b data %h want 1 %h", lookup_hit, lookup_data, DATA_B);
      end
      lookup_address = 12'h056;
      #1;
      n_checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
         n_fail++; $display("FAIL prio_miss: hit %b data %h want 0 0", lookup_hit, lookup_data);
      end
      n_checks++; if (pmem_wdata !== DATA_A) begin n_fail++; $display("FAIL prio_first_write: got %h want %h", pmem_wdata, DATA_A); end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      lookup_address = 12'h055;
      #1;
      n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== DATA_B) begin
         n_fail++; $display("FAIL prio_after_one: hit %b data %h want 1 %h", lookup_hit, lookup_data, DATA_B);
      end
      wait_write();
      n_checks++; if (pmem_address !== 16'h0550 || pmem_wdata !== DATA_B) begin
         n_fail++; $display("FAIL prio_second_write: addr %h data %h want 0550 %h", pmem_address, pmem_wdata, DATA_B);
      end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL prio_cleared: got %b want 0", lookup_hit); end
   endtask

   task automatic test_inflight();
      push_line(12'h0F0, DATA_D);
      tick();
      lookup_address = 12'h0F0;
      #1;
      n_checks++; if (pmem_write !== 1'b1 || lookup_hit !== 1'b1) begin
         n_fail++; $display("FAIL inflight_hit: write %b hit %b want 1 1", pmem_write, lookup_hit);
      end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL inflight_clear: got %b want 0", lookup_hit); end
   endtask

   task automatic test_reset_mid_write();
      push_line(12'h021, DATA_A);
      push_line(12'h022, DATA_B);
      push_line(12'h023, DATA_D);
      n_checks++; if (count !== 3'd3 || pmem_write !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_setup: count %0d write %b want 3 1", count, pmem_write);
      end
      lookup_address = 12'h021;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_write: got %b want 0", pmem_write); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count); end
      n_checks++; if (empty !== 1'b1 || wb_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_flags: empty %b ready %b want 1 1", empty, wb_ready);
      end
      n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL rstmid_lookup: got %b want 0", lookup_hit); end
      reset = 1'b0;
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      n_checks++; if (count !== 3'd0 || pmem_write !== 1'b0) begin
         n_fail++; $display("FAIL stray_resp: count %0d write %b want 0 0", count, pmem_write);
      end
      tick();
      n_checks++; if (pmem_write !== 1'b0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL stray_idle: write %b empty %b want 0 1", pmem_write, empty);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_lookup_priority();
      test_inflight();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/vc_wb_drain.md
Name: vc_wb_drain

Overview:
- Write-back drain buffer on the memory side of the victim cache.
- Accepts dirty victim lines that the victim cache emits on its wb_address/wb_data interface and queues them in a small FIFO.
- Retires queued lines to physical memory one at a time over the LC-3b pmem write handshake.
- Provides a combinational lookup port so an L2 miss can be served from a pending line before that line reaches memory.

Parameters:
- DEPTH, 4, number of queued lines; power of two, minimum 2.
- ADDR_W, 12, line-address width (16-bit byte address minus 4 offset bits).
- DATA_W, 128, line width in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb_valid  input  1  victim cache presents a dirty line this cycle.
- wb_address  input  ADDR_W  line address of the presented line.
- wb_data  input  DATA_W  line data of the presented line.
- wb_ready  output  1  buffer can accept a line; equals !full.
- lookup_address  input  ADDR_W  line address probed by the L2 miss path.
- lookup_hit  output  1  a queued entry matches lookup_address.
- lookup_data  output  DATA_W  data of the youngest matching entry; 0 on miss.
- pmem_address  output  16  byte address {head_addr, 4'b0000}.
- pmem_wdata  output  DATA_W  head entry data.
- pmem_write  output  1  write request to physical memory.
- pmem_resp  input  1  memory has completed the current write.
- empty  output  1  no entries queued.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous): head=0, tail=0, count=0, state=IDLE, pmem_write=0, all valid bits 0, empty=1, wb_ready=1, lookup_hit=0. Array contents are don't-care.
- Enqueue: occurs when wb_valid && wb_ready at a clock edge. The line is written at tail, tail advances modulo DEPTH, count increments.
- Full: wb_ready=0 whenever count==DEPTH, including a cycle in which a pop also occurs; there is no same-cycle refill.
- Simultaneous enqueue and pop (not full): count is unchanged and both pointers advance.
- Duplicate addresses: both entries are queued; no coalescing. Memory sees both writes in order.
- Drain FSM, IDLE:
  - pmem_write=0.
  - If count!=0, go to WRITE next cycle.
- Drain FSM, WRITE:
  - pmem_write=1 (registered state decode).
  - pmem_address and pmem_wdata hold the head entry, stable for the whole request.
  - On pmem_resp=1: pop head (invalidate entry, head advances, count decrements), return to IDLE.
  - This guarantees at least one pmem_write=0 cycle between consecutive writes.
- Stray response: pmem_resp while in IDLE is ignored.
- Latency: for a line enqueued into an empty buffer at edge N, pmem_write rises after edge N+1. The entry is popped on the edge at which pmem_resp is sampled high.
- Outputs in IDLE: pmem_address and pmem_wdata reflect the head entry but are meaningful only while pmem_write=1.
- Lookup:
  - Purely combinational compare against all valid entries.
  - The entry currently being written still counts as a hit until popped.
  - With several matches, the youngest (closest to tail) wins.
  - A line enqueued at edge N is visible to lookup from edge N onward.
- Reset during WRITE: the request is abandoned, pmem_write drops immediately, and all queued lines are discarded.

Decomposition:
- Add to lc3b_types:
  - lc3b_line (logic [127:0])
  - lc3b_line_addr (logic [11:0])
  - enum vc_wb_state_t {VCWB_IDLE, VCWB_WRITE}
- Sub-module vc_wb_queue:
  - Holds the circular storage: address, data and valid arrays, pointers and count.
  - Ports: push, pop, head outputs, and the lookup compare/priority logic.
- vc_wb_drain: instantiates vc_wb_queue and contains only the drain FSM plus the pmem address/wdata formation.

Test Plan:
- Single line: enqueue addr 12'h0A3, data 128'hDEAD…BEEF into an empty buffer. Expect pmem_write=1 one cycle later with pmem_address=16'h0A30 and pmem_wdata matching. Hold pmem_resp low 5 cycles, then assert for 1 cycle: entry popped, empty=1, pmem_write=0 next cycle.
- Fill: with pmem_resp held 0, enqueue 4 lines 12'h001–12'h004. Expect count=4, wb_ready=0; a 5th wb_valid is not accepted. Then drain: memory receives 0x0010, 0x0020, 0x0030, 0x0040 in order, with pmem_write low ≥1 cycle between writes.
- Simultaneous push/pop: with count=2, enqueue on the same edge that pmem_resp pops the head. Expect count stays 2, the new line is at tail, and the next write is the former second entry.
- Lookup priority: enqueue 12'h055/data A, then 12'h055/data B. Expect lookup_address=12'h055 gives lookup_hit=1, lookup_data=B. A lookup of 12'h056 gives hit=0, data=0. After both drain, the hit for 12'h055 clears.
- In-flight lookup: while the head (12'h0F0) is in WRITE awaiting pmem_resp, lookup of 12'h0F0 gives hit=1. On the cycle after pmem_resp, hit=0.
- Reset mid-write: assert reset asynchronously during WRITE with 3 entries queued. Expect pmem_write=0 immediately, count=0, empty=1, wb_ready=1. A later stray pmem_resp causes no change.
